dsi_lane_hs_v2: RTL
===================

Name: dsi_lane_hs_v2

Overview:
- Parametrised next-generation DSI data-lane controller. It buffers byte-wide packet words in an internal FIFO.
- It runs the full LP-11 → LP-01 → LP-00 → HS-zero → sync → data → trail → LP-11 sequence.
- Each timing interval comes from a runtime configuration input.
- It drives a BYTES-wide parallel word to the external lane serializer and the LP line drivers.
- It sits between the packet assembler and the per-lane serializer/IO buffers.

Parameters:
- BYTES, 1, bytes per clk_base cycle (1..4); the serializer ratio is 8*BYTES; byte 0 is transmitted first, LSB first.
- FIFO_DEPTH, 16, words in the input FIFO (power of 2, ≥4).
- CNT_W, 8, width of the timing configuration inputs and the state counter.

Ports:
- clk_base  in  1  logic clock; the only clock.
- reset_n  in  1  reset; synchronous, active-low.
- s_data  in  8*BYTES  packet word.
- s_valid  in  1  word valid.
- s_last  in  1  word is the last of a packet (end of burst).
- s_ready  out  1  FIFO can accept a word.
- cfg_t_lpx  in  CNT_W  LP-01 duration in cycles.
- cfg_t_prep  in  CNT_W  LP-00 duration in cycles.
- cfg_t_zero  in  CNT_W  HS-zero duration in cycles.
- cfg_t_trail  in  CNT_W  HS-trail duration in cycles.
- cfg_t_exit  in  CNT_W  LP-11 hold after HS, in cycles.
- hs_data  out  8*BYTES  parallel word to the serializer.
- hs_oe  out  1  HS driver enable.
- lp_p, lp_n  out  1 each  LP line levels.
- lp_oe  out  1  LP driver enable.
- busy  out  1  not in STOP.
- underrun  out  1  one-cycle pulse: FIFO ran empty mid-burst.

Behaviour:
- Reset (reset_n=0 at a clk_base edge):
  - FIFO and packet count cleared; state=STOP.
  - hs_data=0, hs_oe=0, lp_p=1, lp_n=1, lp_oe=1, busy=0, underrun=0.
  - s_ready=0 while reset is held; s_ready=1 in the first cycle after release.
  - A reset asserted mid-burst aborts immediately to these values.
- FIFO:
  - A word is written when s_valid&&s_ready.
  - s_ready = !full.
  - 9th-bit tag stores s_last.
- Packet counter pkt_cnt:
  - +1 on a write with s_last.
  - −1 on a read of a tagged word.
  - Simultaneous ±1: unchanged.
- Timing:
  - cfg_* are latched into shadow registers on the STOP→LPX transition and held for the whole burst.
  - A config value of 0 is treated as 1.
  - Each timed state lasts exactly max(cfg,1) cycles.
  - A single counter clears on every state change.
- All outputs are registered and change in the same cycle the state changes (decoded from next_state).
- States and outputs:
  - STOP:
    - lp=11, lp_oe=1, hs_oe=0.
    - → LPX when pkt_cnt>0 or FIFO full.
  - LPX: lp=01 (lp_p=1, lp_n=0); lasts t_lpx.
  - PREP: lp=00; lasts t_prep.
  - ZERO: hs_oe=1, lp_oe=0, hs_data=0; lasts t_zero.
  - SYNC:
    - 1 cycle; hs_data has top byte 8'hB8 and all lower bytes 0.
    - B8 = 00011101 in transmit order, so the sync ends on the word boundary.
  - DATA:
    - Pops one word per cycle; hs_data = popped word.
    - The tagged word is followed by → TRAIL.
    - If the FIFO is empty before a tagged word: pulse underrun, go to TRAIL, no pop.
  - TRAIL:
    - hs_data = all bits = ~(last transmitted bit), i.e. the MSB of the final word sent.
    - After SYNC with no data (underrun in the first DATA cycle) the trail value is all-ones.
    - Lasts t_trail.
  - EXIT: hs_oe=0, lp_oe=1, lp=11; lasts t_exit, then → STOP.
- STOP is held for a minimum of 1 cycle between bursts.
- busy=1 in every state except STOP.
- Writes are accepted in every state, including during the burst that is draining.
- A packet arriving during EXIT is sent in the next burst.

Test Plan:
- BYTES=1, cfg lpx=2 prep=2 zero=3 trail=2 exit=2; write one word 0x5A with s_last.
  - Required: LPX2, PREP2, ZERO3, SYNC(0xB8), DATA(0x5A), TRAIL 2×0xFF, EXIT2, STOP.
  - busy high for 13 cycles; hs_oe high for exactly 7.
- BYTES=2, packet 0x80FF,0x1234(last).
  - Required: SYNC word 0xB800; DATA 0x80FF then 0x1234; trail words 0xFFFF (MSB of 0x1234 is 0); pkt_cnt returns to 0.
- All cfg=0.
  - Required: each timed state lasts 1 cycle; shadow latching holds even if cfg changes mid-burst (change cfg_t_trail to 5 during ZERO: trail still 1 cycle).
- Fill FIFO_DEPTH=16 words with no s_last.
  - Required: s_ready drops after the 16th write; burst starts; 16 words sent; underrun pulses once; TRAIL then EXIT.
- Two back-to-back packets (3 words, then 2 words) written while the first burst is in ZERO.
  - Required: two separate bursts with ≥1 STOP cycle between them; second burst carries exactly 2 words.
- reset_n low during DATA.
  - Required: next cycle lp=11, lp_oe=1, hs_oe=0, busy=0, FIFO empty; s_ready=1 one cycle after release.

Source files
------------

// File: rtl/dsi_lane_hs_v2_if.sv
// Signal bundle between the packet assembler / timing config and the DSI HS lane controller,
// including the lane-side outputs towards the serializer and LP drivers.
interface dsi_lane_hs_v2_if #(
    parameter int BYTES = 1,
    parameter int CNT_W = 8
) ();
    logic [8*BYTES-1:0] s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic [CNT_W-1:0]   cfg_t_lpx;
    logic [CNT_W-1:0]   cfg_t_prep;
    logic [CNT_W-1:0]   cfg_t_zero;
    logic [CNT_W-1:0]   cfg_t_trail;
    logic [CNT_W-1:0]   cfg_t_exit;
    logic [8*BYTES-1:0] hs_data;
    logic               hs_oe;
    logic               lp_p;
    logic               lp_n;
    logic               lp_oe;
    logic               busy;
    logic               underrun;

    modport master (
        output s_data, s_valid, s_last,
        output cfg_t_lpx, cfg_t_prep, cfg_t_zero, cfg_t_trail, cfg_t_exit,
        input  s_ready, hs_data, hs_oe, lp_p, lp_n, lp_oe, busy, underrun
    );

    modport slave (
        input  s_data, s_valid, s_last,
        input  cfg_t_lpx, cfg_t_prep, cfg_t_zero, cfg_t_trail, cfg_t_exit,
        output s_ready, hs_data, hs_oe, lp_p, lp_n, lp_oe, busy, underrun
    );
endinterface

// File: rtl/dsi_lane_hs_v2.sv
// DSI data-lane HS burst controller: tagged input FIFO, LP/HS entry and exit sequencing
// with runtime timing, and registered lane outputs decoded from the next state.
module dsi_lane_hs_v2 #(
    parameter int BYTES      = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic            clk_base,
    input  logic            reset_n,
    dsi_lane_hs_v2_if.slave bus
);
    localparam int W  = 8 * BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [W-1:0] SYNC_WORD = W'(8'hB8) << (W - 8);

    typedef enum logic [2:0] {
        ST_STOP, ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL, ST_EXIT
    } state_t;

    state_t           r_state, w_next;
    logic [W:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count, r_pkt_cnt, w_count_nxt;
    logic             r_ready;
    logic [CNT_W-1:0] r_cnt, w_last_cnt;
    logic [CNT_W-1:0] r_t_lpx, r_t_prep, r_t_zero, r_t_trail, r_t_exit;
    logic             r_last_tag, r_last_msb;
    logic [W-1:0]     r_hs_data;
    logic             r_hs_oe, r_lp_p, r_lp_n, r_lp_oe, r_busy, r_underrun;
    logic             w_wr, w_rd, w_full, w_empty, w_timeout, w_underrun;
    logic             w_pkt_inc, w_pkt_dec, w_hs;
    logic [W:0]       w_head;

    // Shadow registers hold the last count index of each interval; a zero config behaves as one.
    function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_wr      = bus.s_valid && r_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_rd      = (w_next == ST_DATA);
    assign w_pkt_inc = w_wr && bus.s_last;
    assign w_pkt_dec = w_rd && w_head[W];
    assign w_timeout = (r_cnt == w_last_cnt);
    assign w_hs      = (w_next == ST_ZERO) || (w_next == ST_SYNC) ||
                       (w_next == ST_DATA) || (w_next == ST_TRAIL);

    // NOTE: storage is deliberately left out of reset; the pointers and count define what is valid.
    always_ff @(posedge clk_base) begin
        if (w_wr) r_mem[r_wr_ptr] <= {bus.s_last, bus.s_data};
    end

    // NOTE: every variable driven from a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd)      w_count_nxt = r_count + CW'(1);
        else if (!w_wr && w_rd) w_count_nxt = r_count - CW'(1);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_base) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pkt_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
            if (w_pkt_inc && !w_pkt_dec)      r_pkt_cnt <= r_pkt_cnt + CW'(1);
            else if (!w_pkt_inc && w_pkt_dec) r_pkt_cnt <= r_pkt_cnt - CW'(1);
        end
    end

    always_comb begin
        w_last_cnt = '0;
        case (r_state)
            ST_LPX:   w_last_cnt = r_t_lpx;
            ST_PREP:  w_last_cnt = r_t_prep;
            ST_ZERO:  w_last_cnt = r_t_zero;
            ST_TRAIL: w_last_cnt = r_t_trail;
            ST_EXIT:  w_last_cnt = r_t_exit;
            default:  w_last_cnt = '0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_underrun = 1'b0;
        case (r_state)
            ST_STOP:  if (r_pkt_cnt != '0 || w_full) w_next = ST_LPX;
            ST_LPX:   if (w_timeout) w_next = ST_PREP;
            ST_PREP:  if (w_timeout) w_next = ST_ZERO;
            ST_ZERO:  if (w_timeout) w_next = ST_SYNC;
            ST_SYNC, ST_DATA: begin
                // A word only enters DATA once popped; an empty FIFO before the tag ends the burst.
                if (r_state == ST_DATA && r_last_tag) begin
                    w_next = ST_TRAIL;
                end else if (w_empty) begin
                    w_next     = ST_TRAIL;
                    w_underrun = 1'b1;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_TRAIL: if (w_timeout) w_next = ST_EXIT;
            ST_EXIT:  if (w_timeout) w_next = ST_STOP;
            default:  w_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk_base) begin
        if (!reset_n) begin
            r_state    <= ST_STOP;
            r_cnt      <= '0;
            r_t_lpx    <= '0;
            r_t_prep   <= '0;
            r_t_zero   <= '0;
            r_t_trail  <= '0;
            r_t_exit   <= '0;
            r_last_tag <= 1'b0;
            r_last_msb <= 1'b0;
            r_hs_data  <= '0;
            r_hs_oe    <= 1'b0;
            r_lp_p     <= 1'b1;
            r_lp_n     <= 1'b1;
            r_lp_oe    <= 1'b1;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_underrun <= w_underrun;

            if (r_state == ST_STOP && w_next == ST_LPX) begin
                r_t_lpx   <= last_of(bus.cfg_t_lpx);
                r_t_prep  <= last_of(bus.cfg_t_prep);
                r_t_zero  <= last_of(bus.cfg_t_zero);
                r_t_trail <= last_of(bus.cfg_t_trail);
                r_t_exit  <= last_of(bus.cfg_t_exit);
            end

            // With no data sent the trail inverts a virtual 0, giving all-ones.
            if (w_rd) begin
                r_last_tag <= w_head[W];
                r_last_msb <= w_head[W-1];
            end else if (w_next == ST_SYNC) begin
                r_last_msb <= 1'b0;
            end

            r_hs_data <= '0;
            r_hs_oe   <= w_hs;
            r_lp_oe   <= !w_hs;
            r_lp_p    <= 1'b1;
            r_lp_n    <= 1'b1;
            r_busy    <= (w_next != ST_STOP);
            case (w_next)
                ST_LPX:   r_lp_n <= 1'b0;
                ST_PREP, ST_ZERO: begin
                    r_lp_p <= 1'b0;
                    r_lp_n <= 1'b0;
                end
                ST_SYNC: begin
                    r_lp_p    <= 1'b0;
                    r_lp_n    <= 1'b0;
                    r_hs_data <= SYNC_WORD;
                end
                ST_DATA: begin
                    r_lp_p    <= 1'b0;
                    r_lp_n    <= 1'b0;
                    r_hs_data <= w_head[W-1:0];
                end
                ST_TRAIL: begin
                    r_lp_p    <= 1'b0;
                    r_lp_n    <= 1'b0;
                    r_hs_data <= {W{~r_last_msb}};
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready  = r_ready;
    assign bus.hs_data  = r_hs_data;
    assign bus.hs_oe    = r_hs_oe;
    assign bus.lp_p     = r_lp_p;
    assign bus.lp_n     = r_lp_n;
    assign bus.lp_oe    = r_lp_oe;
    assign bus.busy     = r_busy;
    assign bus.underrun = r_underrun;
endmodule
